// File: rtl/seg7_pkg.sv
// Shared types and font for the multiplexed 7-segment scan controller.
// Segment bit i drives segment a+i, so bit 0 is a and bit 6 is g.
package seg7_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } scan_state_e;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  function automatic logic [SEG_W-1:0] hex_font(
    input logic [3:0] h
  );
    unique case (h)
      4'h0:    hex_font = 7'h3F;
      4'h1:    hex_font = 7'h06;
      4'h2:    hex_font = 7'h5B;
      4'h3:    hex_font = 7'h4F;
      4'h4:    hex_font = 7'h66;
      4'h5:    hex_font = 7'h6D;
      4'h6:    hex_font = 7'h7D;
      4'h7:    hex_font = 7'h07;
      4'h8:    hex_font = 7'h7F;
      4'h9:    hex_font = 7'h6F;
      4'hA:    hex_font = 7'h77;
      4'hB:    hex_font = 7'h7C;
      4'hC:    hex_font = 7'h39;
      4'hD:    hex_font = 7'h5E;
      4'hE:    hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pwm_gate.sv
// Brightness PWM for one digit slot: latches duty at slot start and
// decides whether segments are lit in the upcoming cycle.
module seg7_pwm_gate
  import seg7_pkg::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slot_end_i,
  input  scan_state_e         state_q_i,
  input  scan_state_e         state_d_i,
  input  logic [PWM_BITS-1:0] bright_i,
  input  logic                blank_i,
  output logic                lit_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic                on_enter;

  always_comb begin
    on_enter  = (state_q_i == DEAD) && (state_d_i == ON);
    bright_d  = slot_end_i ? bright_i : bright_q;
    pwm_cnt_d = pwm_cnt_q;
    if (on_enter) begin
      pwm_cnt_d = '0;
    end else if (state_q_i == ON) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
    // Decision is for the next cycle so the output register aligns with it.
    lit_o = (state_d_i == ON) && !blank_i &&
            ((pwm_cnt_d < bright_d) || (&bright_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      bright_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      bright_q  <= bright_d;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller with shadowed updates committed
// at frame boundaries, anti-ghost dead time and PWM brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES   = 24000,
  parameter int DEAD_CYCLES    = 64,
  parameter int PWM_BITS       = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic                wr_digit_i,
  input  logic                wr_raw_i,
  input  logic [SEG_W-1:0]    wr_data_i,
  input  logic [PWM_BITS-1:0] bright_i,
  input  logic                blank_i,
  output logic [SEG_W-1:0]    seg_pins_o,
  output logic                seg_select_o,
  output logic                frame_o
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [SEG_W-1:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  scan_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic            slot_end;

  logic [SEG_W-1:0] pend_q [2];
  logic [SEG_W-1:0] pend_d [2];
  logic [SEG_W-1:0] act_q  [2];
  logic [SEG_W-1:0] act_d  [2];
  logic [1:0]       pv_q, pv_d;
  logic             ready_q, ready_d;
  logic             frame_q, frame_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [SEG_W-1:0] wr_pat;
  logic             commit, accept, lit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    slot_end = (cnt_q == LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    sel_d    = sel_q ^ slot_end;
    state_d  = state_q;
    unique case (state_q)
      DEAD: if (cnt_q == DEAD_LAST) state_d = ON;
      ON:   if (slot_end) state_d = DEAD;
      default: state_d = DEAD;
    endcase
  end

  seg7_pwm_gate #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .slot_end_i(slot_end),
    .state_q_i (state_q),
    .state_d_i (state_d),
    .bright_i  (bright_i),
    .blank_i   (blank_i),
    .lit_o     (lit)
  );

  always_comb begin
    commit = slot_end & sel_q;
    accept = wr_valid_i & ready_q;
    wr_pat = wr_raw_i ? wr_data_i : hex_font(wr_data_i[3:0]);
    pend_d = pend_q;
    act_d  = act_q;
    pv_d   = pv_q;
    // Commit reads pre-write pending; a same-cycle write waits a frame.
    if (commit) begin
      for (int i = 0; i < 2; i++) begin
        if (pv_q[i]) act_d[i] = pend_q[i];
      end
      pv_d = '0;
    end
    if (accept) begin
      pend_d[wr_digit_i] = wr_pat;
      pv_d[wr_digit_i]   = 1'b1;
    end
    ready_d = ~(pv_d[0] & pv_d[1]);
    frame_d = commit;
    seg_d   = (lit ? act_d[sel_d] : 7'h00) ^ SEG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      pv_q    <= '0;
      ready_q <= 1'b1;
      frame_q <= 1'b0;
      seg_q   <= SEG_OFF;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      pv_q    <= pv_d;
      ready_q <= ready_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
    end
  end

  assign wr_ready_o   = ready_q;
  assign frame_o      = frame_q;
  assign seg_pins_o   = seg_q;
  assign seg_select_o = sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based reference model
// predicts every output cycle and a monitor compares them.
module tb_seg7_scan_ctrl;

  localparam int DW = 16;
  localparam int DC = 2;
  localparam int PB = 2;
  localparam int PM = 1 << PB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          wr_digit = 1'b0;
  logic          wr_raw = 1'b0;
  logic [6:0]    wr_data = '0;
  logic [PB-1:0] bright = '0;
  logic          blank = 1'b0;
  logic [6:0]    seg;
  logic          sel;
  logic          frame;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DWELL_CYCLES  (DW),
    .DEAD_CYCLES   (DC),
    .PWM_BITS      (PB),
    .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_digit_i  (wr_digit),
    .wr_raw_i    (wr_raw),
    .wr_data_i   (wr_data),
    .bright_i    (bright),
    .blank_i     (blank),
    .seg_pins_o  (seg),
    .seg_select_o(sel),
    .frame_o     (frame)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       sel;
    logic       frame;
    logic       ready;
  } obs_t;

  int   total = 0;
  int   bad = 0;
  obs_t expq[$];

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: t counts cycles since reset release.
  int         t;
  logic [6:0] m_pend [2];
  logic [6:0] m_act  [2];
  bit         m_pv   [2];
  bit         m_ready;
  int         m_br;

  task automatic m_reset();
    t = 0;
    m_ready = 1'b1;
    m_br = 0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = '0;
      m_act[i] = '0;
      m_pv[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin : model
    bit   acc, send, com, lit;
    int   pos, slot_sel, ph;
    obs_t e;
    if (rst) begin
      m_reset();
    end else begin
      acc  = wr_valid && m_ready;
      send = (t % DW) == DW - 1;
      com  = send && ((t / DW) % 2 == 1);
      if (com) begin
        for (int i = 0; i < 2; i++)
          if (m_pv[i]) m_act[i] = m_pend[i];
        m_pv[0] = 1'b0;
        m_pv[1] = 1'b0;
      end
      if (acc) begin
        m_pend[wr_digit] = wr_raw ? wr_data : font[wr_data[3:0]];
        m_pv[wr_digit] = 1'b1;
      end
      m_ready = !(m_pv[0] && m_pv[1]);
      if (send) m_br = int'(bright);
      t++;
      pos = t % DW;
      slot_sel = (t / DW) % 2;
      ph = (pos - DC) % PM;
      lit = (pos >= DC) && !blank &&
            ((ph < m_br) || (m_br == PM - 1));
      e.seg   = lit ? m_act[slot_sel] : 7'h00;
      e.sel   = slot_sel[0];
      e.frame = com;
      e.ready = m_ready;
      expq.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    obs_t a, e;
    a.seg = seg;
    a.sel = sel;
    a.frame = frame;
    a.ready = wr_ready;
    if (rst) begin
      expq.delete();
      total++;
      if (a !== obs_t'{seg: 7'h00, sel: 1'b0, frame: 1'b0, ready: 1'b1}) begin
        bad++;
        $display("FAIL reset got seg=%h sel=%b frame=%b ready=%b want seg=00 sel=0 frame=0 ready=1",
                 a.seg, a.sel, a.frame, a.ready);
      end
    end else if (expq.size() > 0) begin
      e = expq.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scan t=%0d got seg=%h sel=%b frame=%b ready=%b want seg=%h sel=%b frame=%b ready=%b",
                 t, a.seg, a.sel, a.frame, a.ready, e.seg, e.sel, e.frame, e.ready);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input bit d, input bit r, input logic [6:0] v);
    bit ok, rdy;
    ok = 1'b0;
    wr_digit = d;
    wr_raw = r;
    wr_data = v;
    wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = wr_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    wr_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wr_timeout got ready=0 for 100 cycles want accept");
    end
  endtask

  task automatic wait_mod(input int m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (t % (2 * DW) == m) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL phase_timeout got t=%0d want phase %0d", t, m);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    step(4);
    rst = 1'b0;
    bright = 2'd3;
    step(70);

    wr(1'b0, 1'b0, 7'h03);
    wr(1'b1, 1'b1, 7'h7F);
    step(80);

    bright = 2'd1;
    step(64);
    bright = 2'd0;
    step(40);
    bright = 2'd3;

    wait_mod(2);
    wr(1'b0, 1'b0, 7'h05);
    wr(1'b1, 1'b0, 7'h06);
    wr(1'b0, 1'b0, 7'h08);
    step(70);

    wr(1'b1, 1'b0, 7'h09);
    wait_mod(31);
    wr_digit = 1'b1;
    wr_raw = 1'b0;
    wr_data = 7'h0A;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    step(80);

    wait_mod(20);
    blank = 1'b1;
    step(3);
    blank = 1'b0;
    step(20);
    wait_mod(7);
    wr(1'b0, 1'b1, 7'h55);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(40);

    for (int k = 0; k < 400; k++) begin
      bright = PB'($urandom);
      blank = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0)
        wr(1'($urandom), 1'($urandom), 7'($urandom));
      else
        step();
    end
    blank = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
